// File: rtl/servo_pwm_rx_multi_if.sv
// Config/result bundle for servo_pwm_rx_multi. Loss-detection signals exist only
// when SERVO_PWM_RX_TIMEOUT_EN is defined.
interface servo_pwm_rx_multi_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned TICK_W = 12
);
  logic [NUM_CH-1:0]        pwm_in;
  logic [TICK_W-1:0]        ui_clk_ticks;
  logic [TICK_W-1:0]        min_ui;
  logic [TICK_W-1:0]        max_ui;
  logic [NUM_CH*TICK_W-1:0] pwm_rx_ui_ticks;
  logic [NUM_CH-1:0]        pwm_rx_ui_ticks_dv;
  logic [NUM_CH-1:0]        pwm_rx_err;
`ifdef SERVO_PWM_RX_TIMEOUT_EN
  logic [TICK_W-1:0]        timeout_ui;
  logic [NUM_CH-1:0]        pwm_rx_lost;

  modport master (
    input  pwm_in, ui_clk_ticks, min_ui, max_ui, timeout_ui,
    output pwm_rx_ui_ticks, pwm_rx_ui_ticks_dv, pwm_rx_err, pwm_rx_lost
  );
  modport slave (
    output pwm_in, ui_clk_ticks, min_ui, max_ui, timeout_ui,
    input  pwm_rx_ui_ticks, pwm_rx_ui_ticks_dv, pwm_rx_err, pwm_rx_lost
  );
`else
  modport master (
    input  pwm_in, ui_clk_ticks, min_ui, max_ui,
    output pwm_rx_ui_ticks, pwm_rx_ui_ticks_dv, pwm_rx_err
  );
  modport slave (
    output pwm_in, ui_clk_ticks, min_ui, max_ui,
    input  pwm_rx_ui_ticks, pwm_rx_ui_ticks_dv, pwm_rx_err
  );
`endif
endinterface

// File: rtl/servo_pwm_rx_multi.sv
// Multi-channel servo PWM high-time receiver, rounded to nearest UI with range flags.
// Optional per-channel signal-loss detection under SERVO_PWM_RX_TIMEOUT_EN.
module servo_pwm_rx_multi #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TICK_W   = 12,
  parameter int unsigned DEGLITCH = 3
) (
  input logic                  clk,
  input logic                  rst,
  servo_pwm_rx_multi_if.master rx_if
);
  localparam logic [TICK_W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIGH, S_DONE} state_e;

  logic [NUM_CH-1:0]   sync1_q, sync2_q, maj_q, maj_d, maj_prev_q, rise_q, fall_q;
  logic [DEGLITCH-1:0] shift_q [NUM_CH];

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [TICK_W-1:0] u_q [NUM_CH];
  logic [TICK_W-1:0] u_d [NUM_CH];
  logic [TICK_W-1:0] r_q [NUM_CH];
  logic [TICK_W-1:0] r_d [NUM_CH];
  logic [TICK_W-1:0] n_q [NUM_CH];
  logic [TICK_W-1:0] n_d [NUM_CH];
  logic [TICK_W-1:0] res_q [NUM_CH];
  logic [TICK_W-1:0] res_d [NUM_CH];
  logic [NUM_CH-1:0] dv_q, dv_d, err_q, err_d;

  function automatic logic maj_vote(input logic [DEGLITCH-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int k = 0; k < int'(DEGLITCH); k++) ones += 32'(v[k]);
    return ones > (DEGLITCH / 2);
  endfunction

  always_comb begin
    maj_d = '0;
    for (int i = 0; i < int'(NUM_CH); i++) maj_d[i] = maj_vote(shift_q[i]);
  end

  // Input path resets high so a channel released mid-pulse must see low before arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      maj_q      <= '1;
      maj_prev_q <= '1;
      rise_q     <= '0;
      fall_q     <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) shift_q[i] <= '1;
    end else begin
      sync1_q    <= rx_if.pwm_in;
      sync2_q    <= sync1_q;
      for (int i = 0; i < int'(NUM_CH); i++)
        shift_q[i] <= {shift_q[i][DEGLITCH-2:0], sync2_q[i]};
      maj_q      <= maj_d;
      maj_prev_q <= maj_q;
      rise_q     <= maj_q & ~maj_prev_q;
      fall_q     <= ~maj_q & maj_prev_q;
    end
  end

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    r_d     = r_q;
    n_d     = n_q;
    res_d   = res_q;
    dv_d    = '0;
    err_d   = err_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      unique case (state_q[i])
        S_IDLE:  if (!maj_q[i]) state_d[i] = S_ARMED;
        S_ARMED: if (rise_q[i]) begin
          state_d[i] = S_HIGH;
          u_d[i]     = rx_if.ui_clk_ticks;
          r_d[i]     = '0;
          n_d[i]     = '0;
        end
        S_HIGH: begin
          if (r_q[i] == u_q[i] - TICK_W'(1)) begin
            r_d[i] = '0;
            if (n_q[i] != ALL_ONES) n_d[i] = n_q[i] + TICK_W'(1);
          end else begin
            r_d[i] = r_q[i] + TICK_W'(1);
          end
          if (fall_q[i]) state_d[i] = S_DONE;
        end
        S_DONE: begin
          // Round half up: compare 2r against U one bit wider so nothing is lost.
          if (n_q[i] == ALL_ONES) begin
            res_d[i] = ALL_ONES;
            err_d[i] = 1'b1;
          end else begin
            res_d[i] = n_q[i] + (({r_q[i], 1'b0} >= {1'b0, u_q[i]}) ? TICK_W'(1) : TICK_W'(0));
            err_d[i] = (res_d[i] < rx_if.min_ui) || (res_d[i] > rx_if.max_ui);
          end
          dv_d[i]    = 1'b1;
          state_d[i] = S_ARMED;
        end
        default: state_d[i] = S_IDLE;
      endcase
      if (rx_if.ui_clk_ticks == '0) begin
        state_d[i] = S_IDLE;
        dv_d[i]    = 1'b0;
        res_d[i]   = res_q[i];
        err_d[i]   = err_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q  <= '0;
      err_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i] <= S_IDLE;
        u_q[i]     <= '0;
        r_q[i]     <= '0;
        n_q[i]     <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      dv_q    <= dv_d;
      err_q   <= err_d;
      state_q <= state_d;
      u_q     <= u_d;
      r_q     <= r_d;
      n_q     <= n_d;
      res_q   <= res_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_out
    assign rx_if.pwm_rx_ui_ticks[g*TICK_W +: TICK_W] = res_q[g];
  end
  assign rx_if.pwm_rx_ui_ticks_dv = dv_q;
  assign rx_if.pwm_rx_err         = err_q;

`ifdef SERVO_PWM_RX_TIMEOUT_EN
  logic [TICK_W-1:0] to_tick_q [NUM_CH];
  logic [TICK_W-1:0] to_tick_d [NUM_CH];
  logic [TICK_W-1:0] to_ui_q [NUM_CH];
  logic [TICK_W-1:0] to_ui_d [NUM_CH];
  logic [NUM_CH-1:0] lost_q, lost_d;

  // UI counter since the last rising edge, tracking the live UI length.
  always_comb begin
    to_tick_d = to_tick_q;
    to_ui_d   = to_ui_q;
    lost_d    = lost_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (rise_q[i]) begin
        to_tick_d[i] = '0;
        to_ui_d[i]   = '0;
      end else if (rx_if.ui_clk_ticks != '0) begin
        if (to_tick_q[i] >= rx_if.ui_clk_ticks - TICK_W'(1)) begin
          to_tick_d[i] = '0;
          if (to_ui_q[i] != ALL_ONES) to_ui_d[i] = to_ui_q[i] + TICK_W'(1);
        end else begin
          to_tick_d[i] = to_tick_q[i] + TICK_W'(1);
        end
      end
      if ((rx_if.timeout_ui != '0) && (to_ui_q[i] == rx_if.timeout_ui)) lost_d[i] = 1'b1;
      if (dv_d[i] && !err_d[i]) lost_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        to_tick_q[i] <= '0;
        to_ui_q[i]   <= '0;
      end
    end else begin
      lost_q    <= lost_d;
      to_tick_q <= to_tick_d;
      to_ui_q   <= to_ui_d;
    end
  end

  assign rx_if.pwm_rx_lost = lost_q;
`endif
endmodule

// File: tb/tb_servo_pwm_rx_multi.sv
// Directed bench for servo_pwm_rx_multi; loss checks added when SERVO_PWM_RX_TIMEOUT_EN is defined.
module tb_servo_pwm_rx_multi;
  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned TICK_W   = 12;
  localparam int unsigned DEGLITCH = 3;
  localparam int          LAT      = DEGLITCH + 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   dv_total0 = 0;

  servo_pwm_rx_multi_if #(.NUM_CH(NUM_CH), .TICK_W(TICK_W)) bus ();

  servo_pwm_rx_multi #(.NUM_CH(NUM_CH), .TICK_W(TICK_W), .DEGLITCH(DEGLITCH)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.pwm_rx_ui_ticks_dv[0] === 1'b1) dv_total0++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [TICK_W-1:0] res_of(input int ch);
    return bus.pwm_rx_ui_ticks[ch*TICK_W +: TICK_W];
  endfunction

  // Low gap, clean high pulse of 'high' clk, then wait for dv; lat = -1 if none.
  task automatic pulse_measure(input int ch, input int high, output int lat,
                               output logic [TICK_W-1:0] res, output logic err);
    lat = -1;
    res = '0;
    err = 1'b0;
    repeat (20) @(negedge clk);
    bus.pwm_in[ch] = 1'b1;
    repeat (high) @(negedge clk);
    bus.pwm_in[ch] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.pwm_rx_ui_ticks_dv[ch] === 1'b1) begin
        lat = k;
        res = res_of(ch);
        err = bus.pwm_rx_err[ch];
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pwm_rx_ui_ticks !== '0) begin
      errors++; $display("FAIL reset_ticks: got %h want 0", bus.pwm_rx_ui_ticks);
    end
    checks++;
    if (bus.pwm_rx_ui_ticks_dv !== '0) begin
      errors++; $display("FAIL reset_dv: got %b want 0", bus.pwm_rx_ui_ticks_dv);
    end
    checks++;
    if (bus.pwm_rx_err !== '0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bus.pwm_rx_err);
    end
`ifdef SERVO_PWM_RX_TIMEOUT_EN
    checks++;
    if (bus.pwm_rx_lost !== '0) begin
      errors++; $display("FAIL reset_lost: got %b want 0", bus.pwm_rx_lost);
    end
`endif
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    int h [3]     = '{1500, 1549, 1550};
    int exp_r [3] = '{15, 15, 16};
    int lat;
    logic [TICK_W-1:0] res;
    logic err;
    for (int t = 0; t < 3; t++) begin
      pulse_measure(0, h[t], lat, res, err);
      checks++;
      if (lat !== LAT) begin
        errors++; $display("FAIL single_lat_%0d: got %0d want %0d", h[t], lat, LAT);
      end
      checks++;
      if (res !== TICK_W'(exp_r[t])) begin
        errors++; $display("FAIL single_res_%0d: got %0d want %0d", h[t], res, exp_r[t]);
      end
      checks++;
      if (err !== 1'b0) begin
        errors++; $display("FAIL single_err_%0d: got %b want 0", h[t], err);
      end
    end
  endtask

  task automatic test_multi();
    logic [NUM_CH-1:0] dvv;
    int exp_r [4] = '{10, 12, 14, 16};
    dvv = '0;
    repeat (20) @(negedge clk);
    bus.pwm_in[3] = 1'b1;
    repeat (200) @(negedge clk);
    bus.pwm_in[2] = 1'b1;
    repeat (200) @(negedge clk);
    bus.pwm_in[1] = 1'b1;
    repeat (200) @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    repeat (1000) @(negedge clk);
    bus.pwm_in = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.pwm_rx_ui_ticks_dv !== '0) begin
        dvv = bus.pwm_rx_ui_ticks_dv;
        break;
      end
    end
    checks++;
    if (dvv !== 4'hF) begin
      errors++; $display("FAIL multi_dv: got %b want 1111", dvv);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (res_of(c) !== TICK_W'(exp_r[c])) begin
        errors++; $display("FAIL multi_res_ch%0d: got %0d want %0d", c, res_of(c), exp_r[c]);
      end
    end
    checks++;
    if (bus.pwm_rx_err !== 4'h0) begin
      errors++; $display("FAIL multi_err: got %b want 0000", bus.pwm_rx_err);
    end
  endtask

  task automatic test_glitch();
    int base;
    logic [TICK_W-1:0] res;
    base = dv_total0;
    res = '0;
    repeat (20) @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    @(negedge clk);
    bus.pwm_in[0] = 1'b0;
    repeat (20) @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    repeat (700) @(negedge clk);
    bus.pwm_in[0] = 1'b0;
    @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    repeat (799) @(negedge clk);
    bus.pwm_in[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.pwm_rx_ui_ticks_dv[0] === 1'b1) begin
        res = res_of(0);
        break;
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (res !== TICK_W'(15)) begin
      errors++; $display("FAIL glitch_res: got %0d want 15", res);
    end
    checks++;
    if (dv_total0 - base !== 1) begin
      errors++; $display("FAIL glitch_dv_count: got %0d want 1", dv_total0 - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int lat;
    logic [TICK_W-1:0] res;
    logic err;
    repeat (20) @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = dv_total0;
    repeat (700) @(negedge clk);
    bus.pwm_in[0] = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (dv_total0 !== base) begin
      errors++; $display("FAIL rstmid_no_dv: got %0d dv want 0", dv_total0 - base);
    end
    checks++;
    if (res_of(0) !== '0) begin
      errors++; $display("FAIL rstmid_ticks: got %0d want 0", res_of(0));
    end
    pulse_measure(0, 1200, lat, res, err);
    checks++;
    if (res !== TICK_W'(12) || lat !== LAT) begin
      errors++; $display("FAIL rstmid_next: got res %0d lat %0d want 12 lat %0d", res, lat, LAT);
    end
  endtask

  task automatic test_sat_range();
    int u [5]     = '{1, 100, 100, 100, 100};
    int h [5]     = '{5000, 500, 2050, 2000, 1000};
    int exp_r [5] = '{4095, 5, 21, 20, 10};
    logic exp_e [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [TICK_W-1:0] res;
    logic err;
    for (int t = 0; t < 5; t++) begin
      bus.ui_clk_ticks = TICK_W'(u[t]);
      pulse_measure(0, h[t], lat, res, err);
      checks++;
      if (res !== TICK_W'(exp_r[t])) begin
        errors++; $display("FAIL range_res_%0d: got %0d want %0d", h[t], res, exp_r[t]);
      end
      checks++;
      if (err !== exp_e[t]) begin
        errors++; $display("FAIL range_err_%0d: got %b want %b", h[t], err, exp_e[t]);
      end
    end
    bus.ui_clk_ticks = TICK_W'(100);
  endtask

  task automatic test_u_control();
    int base;
    int lat;
    logic [TICK_W-1:0] res;
    logic [TICK_W-1:0] prev;
    logic err;
    res = '0;
    repeat (20) @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    repeat (500) @(negedge clk);
    bus.ui_clk_ticks = TICK_W'(50);
    repeat (1000) @(negedge clk);
    bus.pwm_in[0] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.pwm_rx_ui_ticks_dv[0] === 1'b1) begin
        res = res_of(0);
        break;
      end
    end
    bus.ui_clk_ticks = TICK_W'(100);
    checks++;
    if (res !== TICK_W'(15)) begin
      errors++; $display("FAIL uchange_res: got %0d want 15", res);
    end
    prev = res_of(0);
    base = dv_total0;
    repeat (20) @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    repeat (300) @(negedge clk);
    bus.ui_clk_ticks = '0;
    repeat (50) @(negedge clk);
    bus.ui_clk_ticks = TICK_W'(100);
    repeat (300) @(negedge clk);
    bus.pwm_in[0] = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (dv_total0 !== base || res_of(0) !== prev) begin
      errors++; $display("FAIL uzero_hold: got dv %0d res %0d want dv 0 res %0d",
                         dv_total0 - base, res_of(0), prev);
    end
    pulse_measure(0, 1100, lat, res, err);
    checks++;
    if (res !== TICK_W'(11) || err !== 1'b0) begin
      errors++; $display("FAIL uzero_recover: got res %0d err %b want 11 err 0", res, err);
    end
  endtask

`ifdef SERVO_PWM_RX_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    logic [TICK_W-1:0] res;
    logic err;
    logic lost_at_dv;
    bus.timeout_ui = TICK_W'(300);
    repeat (20) @(negedge clk);
    bus.pwm_in[0] = 1'b1;
    repeat (1500) @(negedge clk);
    bus.pwm_in[0] = 1'b0;
    repeat (28400) @(negedge clk);
    checks++;
    if (bus.pwm_rx_lost[0] !== 1'b0) begin
      errors++; $display("FAIL lost_early: got %b want 0", bus.pwm_rx_lost[0]);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (bus.pwm_rx_lost[0] !== 1'b1) begin
      errors++; $display("FAIL lost_set: got %b want 1", bus.pwm_rx_lost[0]);
    end
    pulse_measure(0, 1500, lat, res, err);
    lost_at_dv = bus.pwm_rx_lost[0];
    checks++;
    if (lat !== LAT || lost_at_dv !== 1'b0 || res !== TICK_W'(15)) begin
      errors++; $display("FAIL lost_clear: got lat %0d lost %b res %0d want lat %0d lost 0 res 15",
                         lat, lost_at_dv, res, LAT);
    end
  endtask
`endif

  initial begin
    rst              = 1'b1;
    bus.pwm_in       = '0;
    bus.ui_clk_ticks = TICK_W'(100);
    bus.min_ui       = TICK_W'(10);
    bus.max_ui       = TICK_W'(20);
`ifdef SERVO_PWM_RX_TIMEOUT_EN
    bus.timeout_ui   = '0;
`endif
    test_reset();
    test_single();
    test_multi();
    test_glitch();
    test_reset_mid();
    test_sat_range();
    test_u_control();
`ifdef SERVO_PWM_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
